alu_cmd_queue: RTL and testbench
================================

Name: alu_cmd_queue

Overview:
- Command queue that sits directly upstream of the 4-bit ALU stage.
- Accepts operand/opcode commands {op, a, b} over a valid/ready handshake, filters out commands the ALU cannot execute, buffers them in a small FIFO and issues them one per cycle to the ALU input.
- Absorbs bursts from the pin interface and counts rejected commands.

Parameters:
- DEPTH, 4, number of FIFO entries; power of two, 2..16.
- DATA_W, 4, width of each operand a and b.
- OP_W, 3, opcode width.
- CNT_W, 8, width of the drop counter.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  upstream command valid.
- in_ready  out  1  queue can accept a command this cycle.
- in_op  in  OP_W  opcode (000 AND, 001 OR, 010 ADD, 011 SUB, 100 MUL, 101 DIV, 110/111 illegal).
- in_a  in  DATA_W  operand a.
- in_b  in  DATA_W  operand b.
- out_valid  out  1  command available to ALU.
- out_ready  in  1  ALU consumes command this cycle.
- out_op  out  OP_W  head opcode.
- out_a  out  DATA_W  head operand a.
- out_b  out  DATA_W  head operand b.
- level  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- err_illegal  out  1  one-cycle pulse: illegal opcode rejected.
- err_div0  out  1  one-cycle pulse: DIV with b==0 rejected.
- drop_cnt  out  CNT_W  saturating count of rejected commands.

Behaviour:
- Reset (async assert, sync release):
  - level=0, out_valid=0, in_ready=1.
  - out_op/out_a/out_b=0.
  - err_illegal=0, err_div0=0, drop_cnt=0.
  - Read and write pointers cleared.
- Handshake and output timing:
  - in_ready = (level != DEPTH); combinational from state only, never from in_valid.
  - A command is accepted when in_valid & in_ready at a rising clk edge.
  - out_valid = (level != 0).
  - out_op/out_a/out_b are driven from the head entry, registered storage, with no combinational path from inputs.
  - Pop occurs on out_valid & out_ready.
  - No bypass: a command written into an empty queue appears on out_* with out_valid=1 on the cycle after acceptance. Minimum latency is 1 cycle.
- Filtering, evaluated on accepted commands only:
  - in_op in {110,111}: not stored, err_illegal=1 for the next cycle, drop_cnt+1.
  - in_op==101 and in_b==0: not stored, err_div0=1 for the next cycle, drop_cnt+1.
  - A rejected command still completes its handshake (in_ready asserted) and does not change level.
  - drop_cnt saturates at 2^CNT_W-1; no wrap.
  - Error pulses are one cycle wide. Back-to-back rejects give back-to-back pulses.
- Occupancy updates:
  - Push and pop in the same cycle when level is between 1 and DEPTH-1: level unchanged, both pointers advance.
  - Push (stored) with level=0 and out_ready=1: no pop, since out_valid=0. level becomes 1.
  - level=DEPTH: in_ready=0, so no push. Pop still allowed; in_ready returns to 1 the cycle after the pop.
  - Rejected push with simultaneous pop: level decrements by 1.
- Pointers are log2(DEPTH) bits and wrap naturally at DEPTH. Full/empty are derived from level, not from pointer equality.
- Output stability: out_op/out_a/out_b must hold stable while out_valid=1 and out_ready=0.
- Reset mid-operation: all queued commands are discarded, drop_cnt clears, and outputs return to reset values immediately on rst_n low.

Test Plan:
- Single push, empty queue:
  - Stimulus: push {op=010, a=3, b=5}, out_ready=1.
  - Required: cycle+1 out_valid=1, out_op=010, out_a=3, out_b=5, level=1; cycle+2 out_valid=0, level=0.
- Fill with stalled consumer:
  - Stimulus: out_ready=0, push 5 commands a=1..5, b=1, op=000.
  - Required: after 4 accepts level=4 and in_ready=0; 5th held. Release out_ready: out_a drains in order 1,2,3,4,5; in_ready=1 one cycle after the first pop.
- Filtering:
  - Stimulus: push op=110 a=2 b=2, then op=101 a=9 b=0, then op=101 a=9 b=3.
  - Required: err_illegal pulses once, then err_div0 pulses once; drop_cnt=2; only {101,9,3} emerges; level never exceeds 1.
- Simultaneous push/pop at level 2:
  - Stimulus: in_valid=1, out_ready=1 for 6 cycles with a=0..5.
  - Required: level stays 2; outputs in order, none lost or duplicated; wrap-around exercised.
- Saturation:
  - Stimulus: 300 consecutive op=111 pushes.
  - Required: drop_cnt=255 and holds; level=0 throughout.
- Reset mid-burst:
  - Stimulus: level=3, assert rst_n=0 asynchronously between clock edges.
  - Required: out_valid=0, level=0, drop_cnt=0 without waiting for clk; after release, the first new push is the first output.

Source files
------------

// File: rtl/alu_cmd_queue.sv
// alu_cmd_queue: command FIFO in front of the ALU stage.
// Accepts {op, a, b} commands on a valid/ready handshake and rejects the ones
// the ALU cannot execute: illegal opcodes, and DIV with a zero divisor.
// Accepted commands are buffered and issued one per cycle from registered
// storage.
//
// Ports
//   clk, rst_n               clock, asynchronous active-low reset
//   in_valid/in_ready        upstream handshake; in_ready depends on state only
//   in_op/in_a/in_b          incoming command
//   out_valid/out_ready      ALU-side handshake; a pop happens on valid & ready
//   out_op/out_a/out_b       head entry; all zero while the queue is empty
//   level                    occupancy, 0..DEPTH
//   err_illegal/err_div0     one-cycle pulses, one per rejected command
//   drop_cnt                 saturating count of rejected commands
module alu_cmd_queue #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 4,
    parameter int OP_W   = 3,
    parameter int CNT_W  = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [OP_W-1:0]            in_op,
    input  logic [DATA_W-1:0]          in_a,
    input  logic [DATA_W-1:0]          in_b,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [OP_W-1:0]            out_op,
    output logic [DATA_W-1:0]          out_a,
    output logic [DATA_W-1:0]          out_b,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       err_illegal,
    output logic                       err_div0,
    output logic [CNT_W-1:0]           drop_cnt
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam logic [LVL_W-1:0] FULL   = LVL_W'(DEPTH);
    localparam logic [OP_W-1:0]  OP_DIV = OP_W'(5);

    typedef struct packed {
        logic [OP_W-1:0]   op;
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
    } cmd_t;

    cmd_t             mem [DEPTH];
    cmd_t             head;
    logic [PTR_W-1:0] wr_ptr, rd_ptr;

    logic accept, op_illegal, op_div0, reject, store, pop;

    assign in_ready  = (level != FULL);
    assign out_valid = (level != '0);

    assign op_illegal = (in_op > OP_DIV);
    assign op_div0    = (in_op == OP_DIV) && (in_b == '0);

    assign accept = in_valid & in_ready;
    assign reject = accept & (op_illegal | op_div0);
    assign store  = accept & ~op_illegal & ~op_div0;
    assign pop    = out_valid & out_ready;

    // Storage is never reset; the empty-queue mask below keeps stale
    // entries off the outputs, so a reset still shows all-zero outputs.
    always_ff @(posedge clk) begin
        if (store)
            mem[wr_ptr] <= '{op: in_op, a: in_a, b: in_b};
    end

    assign head   = mem[rd_ptr];
    assign out_op = out_valid ? head.op : '0;
    assign out_a  = out_valid ? head.a  : '0;
    assign out_b  = out_valid ? head.b  : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            level       <= '0;
            err_illegal <= 1'b0;
            err_div0    <= 1'b0;
            drop_cnt    <= '0;
        end else begin
            if (store) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)   rd_ptr <= rd_ptr + PTR_W'(1);

            // A rejected command never touches level, so only the
            // stored/popped combination matters here.
            case ({store, pop})
                2'b10:   level <= level + LVL_W'(1);
                2'b01:   level <= level - LVL_W'(1);
                default: level <= level;
            endcase

            err_illegal <= accept & op_illegal;
            err_div0    <= accept & op_div0;

            if (reject && (drop_cnt != '1))
                drop_cnt <= drop_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_alu_cmd_queue.sv
// Testbench for alu_cmd_queue: directed scenarios with literal expectations,
// plus a queue-based reference model compared against the DUT every cycle.
module tb_alu_cmd_queue;

    localparam int DEPTH = 4;

    logic       clk, rst_n;
    logic       in_valid, in_ready, out_valid, out_ready;
    logic [2:0] in_op, out_op;
    logic [3:0] in_a, in_b, out_a, out_b;
    logic [2:0] level;
    logic       err_illegal, err_div0;
    logic [7:0] drop_cnt;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 0;

    alu_cmd_queue #(.DEPTH(DEPTH), .DATA_W(4), .OP_W(3), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_a(in_a), .in_b(in_b),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_op(out_op), .out_a(out_a), .out_b(out_b),
        .level(level), .err_illegal(err_illegal), .err_div0(err_div0),
        .drop_cnt(drop_cnt)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        int op;
        int a;
        int b;
    } mcmd_t;

    mcmd_t m_q[$];
    int    m_drop;
    bit    m_ill, m_div;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_q.delete();
            m_drop = 0;
            m_ill  = 0;
            m_div  = 0;
        end else begin
            bit    acc, pop, bad_op, bad_div;
            mcmd_t c;
            acc     = in_valid && (m_q.size() < DEPTH);
            pop     = (m_q.size() > 0) && out_ready;
            bad_op  = (in_op >= 6);
            bad_div = (in_op == 5) && (in_b == 0);
            m_ill   = acc && bad_op;
            m_div   = acc && bad_div;
            if (pop) void'(m_q.pop_front());
            if (acc && !bad_op && !bad_div) begin
                c.op = in_op; c.a = in_a; c.b = in_b;
                m_q.push_back(c);
            end
            if (acc && (bad_op || bad_div) && m_drop < 255) m_drop++;
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            int n;
            n = m_q.size();
            chk("m_level", level, n);
            chk("m_in_ready", in_ready, (n != DEPTH) ? 1 : 0);
            chk("m_out_valid", out_valid, (n != 0) ? 1 : 0);
            chk("m_out_op", out_op, (n != 0) ? m_q[0].op : 0);
            chk("m_out_a", out_a, (n != 0) ? m_q[0].a : 0);
            chk("m_out_b", out_b, (n != 0) ? m_q[0].b : 0);
            chk("m_err_illegal", err_illegal, m_ill ? 1 : 0);
            chk("m_err_div0", err_div0, m_div ? 1 : 0);
            chk("m_drop_cnt", drop_cnt, m_drop);
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Holds a command until it is accepted; a bounded wait counts as a failure.
    task automatic push(input int op, input int a, input int b);
        bit acc;
        int n;
        in_valid = 1;
        in_op = 3'(op); in_a = 4'(a); in_b = 4'(b);
        n = 0;
        do begin
            acc = in_ready;
            cyc();
            n++;
        end while (!acc && n < 50);
        if (!acc) chk("push_timeout", 0, 1);
        in_valid = 0;
    endtask

    initial begin
        rst_n = 0; in_valid = 0; out_ready = 0;
        in_op = 0; in_a = 0; in_b = 0;
        #2;
        chk("rst_level", level, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_a", out_a, 0);
        chk("rst_drop", drop_cnt, 0);
        chk("rst_err", {err_illegal, err_div0}, 0);
        @(negedge clk);
        rst_n = 1;
        cmp_en = 1;
        cyc();

        // single push into empty queue
        out_ready = 1;
        push(3'b010, 3, 5);
        chk("single_valid", out_valid, 1);
        chk("single_op", out_op, 2);
        chk("single_a", out_a, 3);
        chk("single_b", out_b, 5);
        chk("single_level", level, 1);
        cyc();
        chk("single_valid2", out_valid, 0);
        chk("single_level2", level, 0);

        // fill with stalled consumer
        out_ready = 0;
        for (int i = 1; i <= 4; i++) push(0, i, 1);
        chk("fill_level", level, 4);
        chk("fill_in_ready", in_ready, 0);
        in_valid = 1; in_op = 0; in_a = 5; in_b = 1;
        cyc();
        chk("fill_held", level, 4);
        chk("fill_head", out_a, 1);
        out_ready = 1;
        cyc();
        chk("drain_a2", out_a, 2);
        chk("drain_ready", in_ready, 1);
        chk("drain_lvl3", level, 3);
        cyc();
        in_valid = 0;
        chk("drain_a3", out_a, 3);
        chk("drain_lvl3b", level, 3);
        cyc();
        chk("drain_a4", out_a, 4);
        cyc();
        chk("drain_a5", out_a, 5);
        cyc();
        chk("drain_empty", out_valid, 0);

        // filtering
        push(3'b110, 2, 2);
        chk("filt_ill", err_illegal, 1);
        chk("filt_lvl0", level, 0);
        chk("filt_drop1", drop_cnt, 1);
        push(3'b101, 9, 0);
        chk("filt_div", err_div0, 1);
        chk("filt_ill_off", err_illegal, 0);
        chk("filt_drop2", drop_cnt, 2);
        push(3'b101, 9, 3);
        chk("filt_div_off", err_div0, 0);
        chk("filt_out_op", out_op, 5);
        chk("filt_out_a", out_a, 9);
        chk("filt_out_b", out_b, 3);
        chk("filt_lvl1", level, 1);
        cyc();
        chk("filt_lvl_end", level, 0);

        // simultaneous push/pop at level 2, pointers wrap
        out_ready = 0;
        push(2, 10, 1);
        push(2, 11, 1);
        chk("pp_lvl_start", level, 2);
        out_ready = 1;
        for (int i = 0; i < 6; i++) begin
            in_valid = 1; in_op = 2; in_a = 4'(i); in_b = 1;
            cyc();
            chk("pp_level", level, 2);
            chk("pp_head", out_a, (i == 0) ? 11 : i - 1);
        end
        in_valid = 0;
        cyc(); cyc();
        chk("pp_lvl_end", level, 0);

        // saturation of drop counter (starts at 2)
        in_valid = 1; in_op = 3'b111; in_a = 0; in_b = 0;
        for (int i = 0; i < 300; i++) begin
            cyc();
            if (level != 0) chk("sat_level", level, 0);
        end
        in_valid = 0;
        chk("sat_drop", drop_cnt, 255);
        cyc();
        chk("sat_hold", drop_cnt, 255);
        chk("sat_ill_off", err_illegal, 0);

        // asynchronous reset mid-burst
        out_ready = 0;
        for (int i = 1; i <= 3; i++) push(1, i, 2);
        chk("rb_level", level, 3);
        #2;
        rst_n = 0;
        #1;
        chk("rb_out_valid", out_valid, 0);
        chk("rb_level0", level, 0);
        chk("rb_drop0", drop_cnt, 0);
        chk("rb_in_ready", in_ready, 1);
        chk("rb_out_a", out_a, 0);
        @(posedge clk);
        #3;
        rst_n = 1;
        out_ready = 1;
        push(1, 7, 4);
        chk("rb_first_valid", out_valid, 1);
        chk("rb_first_a", out_a, 7);
        chk("rb_first_lvl", level, 1);
        cyc();
        chk("rb_end_lvl", level, 0);

        cyc();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
